// File: rtl/audio_stream_source.sv
// Bit-serial audio packet source: CSR-fed sample FIFO feeding an MSB-first
// serializer with valid/ready flow control and zero-bubble back-to-back packets.
module audio_stream_source #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESETn,
  input  logic [2:0]  iCSR_ADDRESS,
  input  logic        iCSR_READ,
  output logic [31:0] oCSR_READ_DATA,
  input  logic        iCSR_WRITE,
  input  logic [31:0] iCSR_WRITE_DATA,
  output logic        s_clock,
  output logic        s_data_valid,
  input  logic        s_ready,
  output logic        s_start_packet,
  output logic        s_end_packet,
  output logic        s_data
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IW    = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(SAMPLE_WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                    state_q, state_d;
  logic [SAMPLE_WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]        wr_ptr, rd_ptr;
  logic [FIFO_AW:0]          level;
  logic [SAMPLE_WIDTH-1:0]   shift_q;
  logic [IW-1:0]             idx_q;
  logic                      en_q, ovf_q, und_q;
  logic [31:0]               sent_q, rd_mux;
  logic                      fifo_full, fifo_empty, flush, push_req, push, pop;
  logic                      shift_en, sent_inc, und_set, ovf_set, sts_wr;
  logic                      unused_wdata;

  assign s_clock      = iCLOCK;
  assign fifo_full    = (level == (FIFO_AW+1)'(DEPTH));
  assign fifo_empty   = (level == '0);
  assign flush        = iCSR_WRITE && (iCSR_ADDRESS == 3'd0) && iCSR_WRITE_DATA[1];
  assign sts_wr       = iCSR_WRITE && (iCSR_ADDRESS == 3'd1);
  assign push_req     = iCSR_WRITE && (iCSR_ADDRESS == 3'd2);
  // FULL is judged on the registered level, so a same-cycle pop never admits a push
  assign push         = push_req && !fifo_full && !flush;
  assign ovf_set      = push_req && fifo_full;
  assign unused_wdata = ^iCSR_WRITE_DATA;

  // Stream outputs decode directly from flops so reset clears them at once
  assign s_data_valid   = (state_q == S_SHIFT);
  assign s_data         = s_data_valid && shift_q[idx_q];
  assign s_start_packet = s_data_valid && (idx_q == IDX_MSB);
  assign s_end_packet   = s_data_valid && (idx_q == '0);

  always_ff @(posedge iCLOCK or negedge iRESETn)
    if (!iRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    shift_en = 1'b0;
    sent_inc = 1'b0;
    und_set  = 1'b0;
    case (state_q)
      S_IDLE:
        if (en_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = S_SHIFT;
        end
      S_SHIFT:
        if (s_ready) begin
          if (idx_q != '0) shift_en = 1'b1;
          else begin
            sent_inc = 1'b1;
            if (en_q && !fifo_empty) pop = 1'b1;
            else begin
              state_d = S_IDLE;
              und_set = en_q;
            end
          end
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK)
    if (push) mem[wr_ptr] <= iCSR_WRITE_DATA[SAMPLE_WIDTH-1:0];

  always_ff @(posedge iCLOCK or negedge iRESETn)
    if (!iRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end

  always_ff @(posedge iCLOCK or negedge iRESETn)
    if (!iRESETn) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (pop) begin
      shift_q <= mem[rd_ptr];
      idx_q   <= IDX_MSB;
    end else if (shift_en) begin
      idx_q   <= idx_q - 1'b1;
    end

  always_ff @(posedge iCLOCK or negedge iRESETn)
    if (!iRESETn) begin
      en_q   <= 1'b0;
      ovf_q  <= 1'b0;
      und_q  <= 1'b0;
      sent_q <= '0;
    end else begin
      if (iCSR_WRITE && (iCSR_ADDRESS == 3'd0)) en_q <= iCSR_WRITE_DATA[0];
      // a new event in the same cycle as a clear keeps the flag set
      ovf_q <= ovf_set | (ovf_q & ~(sts_wr & iCSR_WRITE_DATA[24]));
      und_q <= und_set | (und_q & ~(sts_wr & iCSR_WRITE_DATA[25]));
      if (sent_inc) sent_q <= sent_q + 32'd1;
    end

  always_comb begin
    rd_mux = '0;
    case (iCSR_ADDRESS)
      3'd0: rd_mux[0] = en_q;
      3'd1: begin
        rd_mux[FIFO_AW:0] = level;
        rd_mux[16]        = fifo_empty;
        rd_mux[17]        = fifo_full;
        rd_mux[24]        = ovf_q;
        rd_mux[25]        = und_q;
      end
      3'd3:    rd_mux = sent_q;
      3'd4:    rd_mux = 32'h0000_A5C0 | 32'(SAMPLE_WIDTH);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge iRESETn)
    if (!iRESETn)       oCSR_READ_DATA <= '0;
    else if (iCSR_READ) oCSR_READ_DATA <= rd_mux;

endmodule

// File: tb/tb_audio_stream_source.sv
// Bench for audio_stream_source: CSR vector tables, packet scoreboard fed on
// DATA writes, bit-level monitor with stall stability checks.
module tb_audio_stream_source;
  localparam int SW = 16;

  logic        clk = 0, rst_n = 0;
  logic [2:0]  addr = '0;
  logic        rd = 0, wr = 0;
  logic [31:0] wdata = '0, rdata;
  logic        s_clock, s_data_valid, s_ready, s_start_packet, s_end_packet, s_data;

  audio_stream_source #(.SAMPLE_WIDTH(SW), .FIFO_AW(4)) dut (
    .iCLOCK(clk), .iRESETn(rst_n), .iCSR_ADDRESS(addr), .iCSR_READ(rd),
    .oCSR_READ_DATA(rdata), .iCSR_WRITE(wr), .iCSR_WRITE_DATA(wdata),
    .s_clock(s_clock), .s_data_valid(s_data_valid), .s_ready(s_ready),
    .s_start_packet(s_start_packet), .s_end_packet(s_end_packet), .s_data(s_data));

  always #5 clk = ~clk;

  typedef struct { logic [2:0] a; logic [31:0] exp; string nm; } rd_vec_t;
  rd_vec_t rst_tbl[8];

  int n_cmp = 0, n_err = 0;
  logic [SW-1:0] sb_q[$];
  int  mon_cnt = 0;
  bit  bp_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1;
    @(negedge clk); wr = 0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1;
    @(negedge clk); rd = 0; d = rdata;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic push(input logic [SW-1:0] v, input bit expect_tx);
    csr_wr(3'd2, 32'(v));
    if (expect_tx) sb_q.push_back(v);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || s_data_valid) && t < 600) begin @(negedge clk); t++; end
    chk("drain_timeout", 32'(t < 600), 32'd1);
  endtask

  task automatic run_rst_tbl(input string tag);
    for (int i = 0; i < 8; i++) rd_chk({tag, rst_tbl[i].nm}, rst_tbl[i].a, rst_tbl[i].exp);
  endtask

  // s_ready changes just after the active edge so the negedge monitor sees it settled
  initial begin
    s_ready = 1;
    forever begin
      @(posedge clk); #2;
      s_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // bit monitor: flag checks per accepted bit, hold checks across stalls, packet scoreboard
  initial begin
    logic [SW-1:0] shreg = '0;
    bit   stall = 0;
    logic p_d = 0, p_s = 0, p_e = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_cnt = 0; stall = 0;
      end else begin
        if (stall) begin
          chk("stall_valid", 32'(s_data_valid), 32'd1);
          chk("stall_hold", 32'({s_data, s_start_packet, s_end_packet}), 32'({p_d, p_s, p_e}));
        end
        if (s_data_valid && s_ready) begin
          chk("start_flag", 32'(s_start_packet), 32'(mon_cnt == 0));
          chk("end_flag", 32'(s_end_packet), 32'(mon_cnt == SW-1));
          shreg = {shreg[SW-2:0], s_data};
          mon_cnt++;
          if (mon_cnt == SW) begin
            mon_cnt = 0;
            if (sb_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_pkt: got 0x%04h expected none", shreg);
            end else chk("pkt_data", 32'(shreg), 32'(sb_q.pop_front()));
          end
        end
        stall = s_data_valid && !s_ready;
        p_d = s_data; p_s = s_start_packet; p_e = s_end_packet;
      end
    end
  end

  initial begin
    int exp_sent = 0;
    int run, starts, t;

    rst_tbl[0] = '{3'd0, 32'h0000_0000, "ctrl"};
    rst_tbl[1] = '{3'd1, 32'h0001_0000, "status"};
    rst_tbl[2] = '{3'd2, 32'h0000_0000, "data"};
    rst_tbl[3] = '{3'd3, 32'h0000_0000, "sent"};
    rst_tbl[4] = '{3'd4, 32'h0000_A5D0, "id"};
    rst_tbl[5] = '{3'd5, 32'h0000_0000, "a5"};
    rst_tbl[6] = '{3'd6, 32'h0000_0000, "a6"};
    rst_tbl[7] = '{3'd7, 32'h0000_0000, "a7"};

    #1;
    chk("rst_stream", 32'({s_data_valid, s_data, s_start_packet, s_end_packet}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_rst_tbl("rst_");

    // basic packet and first-bit latency
    csr_wr(3'd0, 32'd1);
    push(16'hA5C3, 1);
    chk("lat_n1_valid", 32'(s_data_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(s_data_valid), 32'd1);
    chk("lat_n2_start", 32'(s_start_packet), 32'd1);
    drain(); exp_sent++;
    rd_chk("basic_sent", 3'd3, 32'(exp_sent));
    rd_chk("basic_status", 3'd1, 32'h0201_0000);
    csr_wr(3'd1, 32'h0200_0000);
    rd_chk("und_clr", 3'd1, 32'h0001_0000);

    // backpressure
    bp_mode = 1;
    push(16'h8001, 1);
    drain(); exp_sent++;
    bp_mode = 0;
    rd_chk("bp_sent", 3'd3, 32'(exp_sent));
    csr_wr(3'd1, 32'h0200_0000);

    // back-to-back from a pre-filled FIFO
    csr_wr(3'd0, 32'd0);
    push(16'h1234, 1); push(16'hFFFF, 1); push(16'h0000, 1);
    rd_chk("b2b_level", 3'd1, 32'h0000_0003);
    csr_wr(3'd0, 32'd1);
    t = 0;
    while (!s_data_valid && t < 10) begin @(negedge clk); t++; end
    run = 0; starts = 0;
    while (s_data_valid && run < 100) begin
      run++;
      if (s_start_packet) starts++;
      @(negedge clk);
    end
    chk("b2b_run", 32'(run), 32'd48);
    chk("b2b_starts", 32'(starts), 32'd3);
    drain(); exp_sent += 3;
    rd_chk("b2b_sent", 3'd3, 32'(exp_sent));
    rd_chk("b2b_status", 3'd1, 32'h0201_0000);
    csr_wr(3'd1, 32'h0200_0000);

    // overflow, W1C and flush
    csr_wr(3'd0, 32'd0);
    for (int i = 0; i < 17; i++) push(16'(i * 3 + 1), 0);
    rd_chk("ovf_status", 3'd1, 32'h0102_0010);
    csr_wr(3'd1, 32'h0100_0000);
    rd_chk("ovf_clr", 3'd1, 32'h0002_0010);
    csr_wr(3'd0, 32'd2);
    rd_chk("flush_status", 3'd1, 32'h0001_0000);
    rd_chk("flush_ctrl", 3'd0, 32'd0);

    // disable + flush while a packet is in flight
    push(16'hF00F, 1); push(16'h1111, 0); push(16'h2222, 0); push(16'h3333, 0);
    csr_wr(3'd0, 32'd1);
    t = 0;
    while (mon_cnt < 5 && t < 50) begin @(negedge clk); t++; end
    chk("mid_reach_bit5", 32'(t < 50), 32'd1);
    csr_wr(3'd0, 32'd0);
    csr_wr(3'd0, 32'd2);
    drain(); exp_sent++;
    repeat (20) @(negedge clk);
    chk("mid_idle", 32'(s_data_valid), 32'd0);
    rd_chk("mid_status", 3'd1, 32'h0001_0000);
    rd_chk("mid_sent", 3'd3, 32'(exp_sent));

    // asynchronous reset in the middle of a packet
    csr_wr(3'd0, 32'd1);
    push(16'h1357, 1);
    t = 0;
    while (mon_cnt < 8 && t < 50) begin @(negedge clk); t++; end
    chk("ar_reach_bit8", 32'(t < 50), 32'd1);
    #1 rst_n = 0;
    #1 chk("ar_stream", 32'({s_data_valid, s_data, s_start_packet, s_end_packet}), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    run_rst_tbl("ar_");
    csr_wr(3'd0, 32'd1);
    push(16'hBEEF, 1);
    drain();
    rd_chk("ar_sent", 3'd3, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
